// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO in front of a UART transmitter. Host writes are
// buffered and launched one at a time with a single-cycle tx_start pulse; the
// next word is only launched after the transmitter reports tx_done_tick.
//
// Host side handshake: wr_en is a one-cycle strobe carrying wr_data. The word
// is taken on that edge only if full was low at the start of the cycle. A
// strobe while full is dropped, and overflow is high for the following cycle.
// Transmitter side: tx_din is held from the pop until the next pop, and
// tx_start is asserted for one cycle per word. No further tx_start is issued
// until tx_done_tick has been seen for the word in flight.
module uart_tx_feeder #(
    parameter int DBIT   = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [DBIT-1:0]   wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              busy,
    input  logic              tx_done_tick,
    output logic              tx_start,
    output logic [DBIT-1:0]   tx_din
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DBIT-1:0]   mem_q [DEPTH];
    logic [DBIT-1:0]   mem_d [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DBIT-1:0]   tx_din_q, tx_din_d;
    logic              overflow_q, overflow_d;

    logic wr_accept;
    logic pop;

    // FIFO flags come straight from the registered count
    always_comb begin
        full      = (count_q == CNT_FULL);
        empty     = (count_q == '0);
        level     = count_q;
        wr_accept = wr_en & ~full;
    end

    // State register: reset abandons any word in flight
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: launch one word, then hold until the frame completes
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = LAUNCH;
            LAUNCH:  state_d = WAIT;
            WAIT:    if (tx_done_tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: pop only from IDLE, start pulse decoded from LAUNCH
    always_comb begin
        pop      = (state_q == IDLE) & ~empty;
        tx_start = (state_q == LAUNCH);
        busy     = (state_q != IDLE) | ~empty;
        tx_din   = tx_din_q;
        overflow = overflow_q;
    end

    // FIFO datapath: storage, pointers, occupancy and output word
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        tx_din_d   = tx_din_q;
        overflow_d = wr_en & full;
        if (wr_accept) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            tx_din_d = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage array needs no reset: occupancy decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control registers of the FIFO and the transmitter-facing word
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_din_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_din_q   <= tx_din_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder: reset, single frame, burst ordering,
// overflow at full, pointer wrap with random done delays, reset mid-frame.
module tb_uart_tx_feeder;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       busy;
    logic       tx_done_tick;
    logic       tx_start;
    logic [7:0] tx_din;

    int checks;
    int failures;
    int starts;
    int dones;
    logic outstanding;
    logic [7:0] exp_q[$];

    uart_tx_feeder #(.DBIT(8), .ADDR_W(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .busy         (busy),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_din       (tx_din)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample #1 after the edge, score any launched word
    task automatic step();
        logic       done_sent;
        logic [8:0] e;
        done_sent = tx_done_tick;
        @(posedge clk);
        #1;
        if (done_sent) begin
            outstanding = 1'b0;
            dones++;
        end
        if (tx_start === 1'b1) begin
            e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
            chk("start_data", 32'(tx_din), 32'(e));
            chk("start_single", 32'(outstanding), 32'd0);
            outstanding = 1'b1;
            starts++;
        end
    endtask

    task automatic write_word(input logic [7:0] d, input logic accept);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) exp_q.push_back(d);
        step();
        wr_en = 1'b0;
    endtask

    // Answer n launches, each with a done tick dly cycles after the launch
    task automatic serve(input int n, input int lo, input int hi);
        int guard;
        int dly;
        for (int f = 0; f < n; f++) begin
            guard = 0;
            while (!outstanding && guard < 200) begin
                step();
                guard++;
            end
            chk("start_timeout", 32'(outstanding), 32'd1);
            if (outstanding) begin
                dly = $urandom_range(hi, lo);
                for (int k = 0; k < dly; k++) step();
                tx_done_tick = 1'b1;
                step();
                tx_done_tick = 1'b0;
            end
        end
    endtask

    initial begin
        int s0;
        int d0;
        checks       = 0;
        failures     = 0;
        starts       = 0;
        dones        = 0;
        outstanding  = 1'b0;
        reset_n      = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_done_tick = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_din",   32'(tx_din),   32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_level",    32'(level),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        reset_n = 1'b1;

        // Idle 20 cycles
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_tx_start", 32'(tx_start), 32'd0);
            chk("idle_empty",    32'(empty),    32'd1);
            chk("idle_level",    32'(level),    32'd0);
            chk("idle_busy",     32'(busy),     32'd0);
        end

        // Single frame: write at N, launch at N+2, done 10 cycles after launch
        write_word(8'hA5, 1'b1);
        chk("one_level_n1",  32'(level),    32'd1);
        chk("one_empty_n1",  32'(empty),    32'd0);
        chk("one_start_n1",  32'(tx_start), 32'd0);
        step();
        chk("one_start_n2",  32'(tx_start), 32'd1);
        chk("one_din_n2",    32'(tx_din),   32'hA5);
        chk("one_level_n2",  32'(level),    32'd0);
        chk("one_busy_n2",   32'(busy),     32'd1);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("one_wait_start", 32'(tx_start), 32'd0);
            chk("one_wait_busy",  32'(busy),     32'd1);
        end
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("one_idle_busy",  32'(busy),     32'd0);
        chk("one_idle_start", 32'(tx_start), 32'd0);
        step();
        chk("one_after_start", 32'(tx_start), 32'd0);

        // Burst 0x00..0x0F, no done ticks: first pop keeps full low
        for (int i = 0; i < 16; i++) begin
            write_word(8'(i), 1'b1);
            chk("burst_not_full", 32'(full), 32'd0);
        end
        chk("burst_level", 32'(level), 32'd15);
        serve(16, 1, 4);
        chk("burst_drain_empty", 32'(empty), 32'd1);
        chk("burst_drain_busy",  32'(busy),  32'd0);

        // Fill to 16 behind a stalled frame, then overflow
        write_word(8'h11, 1'b1);
        step();
        step();
        for (int i = 0; i < 16; i++) write_word(8'h20 + 8'(i), 1'b1);
        chk("fill_full",  32'(full),  32'd1);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_ovf_quiet", 32'(overflow), 32'd0);
        write_word(8'hFF, 1'b0);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_level", 32'(level),    32'd16);
        step();
        chk("ovf_clear", 32'(overflow), 32'd0);
        chk("ovf_level2", 32'(level),   32'd16);
        // Write at full in the same cycle as a pop is still dropped
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        chk("popfull_full", 32'(full), 32'd1);
        write_word(8'hEE, 1'b0);
        chk("popfull_ovf",   32'(overflow), 32'd1);
        chk("popfull_level", 32'(level),    32'd15);
        chk("popfull_start", 32'(tx_start), 32'd1);
        serve(16, 1, 3);
        chk("fill_drain_empty", 32'(empty), 32'd1);
        chk("fill_drain_level", 32'(level), 32'd0);
        chk("fill_drain_busy",  32'(busy),  32'd0);

        // Pointer wrap: 40 random words, random done delays
        s0 = starts;
        d0 = dones;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 10; i++) write_word(8'($urandom_range(255, 0)), 1'b1);
            serve(10, 1, 30);
        end
        chk("wrap_starts", 32'(starts - s0), 32'd40);
        chk("wrap_dones",  32'(dones - d0),  32'd40);
        chk("wrap_left",   32'(exp_q.size()), 32'd0);
        chk("wrap_empty",  32'(empty), 32'd1);

        // Reset while in WAIT with 5 words queued
        for (int i = 0; i < 6; i++) write_word(8'h30 + 8'(i), 1'b1);
        step();
        chk("mid_level", 32'(level), 32'd5);
        chk("mid_outstanding", 32'(outstanding), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_q.delete();
        outstanding = 1'b0;
        chk("mid_rst_level", 32'(level),    32'd0);
        chk("mid_rst_empty", 32'(empty),    32'd1);
        chk("mid_rst_din",   32'(tx_din),   32'd0);
        chk("mid_rst_busy",  32'(busy),     32'd0);
        chk("mid_rst_start", 32'(tx_start), 32'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("mid_quiet_start", 32'(tx_start), 32'd0);
        end
        write_word(8'h5A, 1'b1);
        chk("post_level", 32'(level), 32'd1);
        step();
        chk("post_start", 32'(tx_start), 32'd1);
        chk("post_din",   32'(tx_din),   32'h5A);
        serve(1, 2, 5);
        chk("post_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
